// File: rtl/factor_game_ctrl.sv
// factor_game_ctrl: round sequencer for the factorization quiz (READY -> QUESTION -> INPUT -> CORRECT/MISS).
// Ports: CLK/RST (async active-high), START/ENTER button levels, SW answer switches;
//        STATE phase code, QUE question digit, DIN entered answer, SCORE, ROUND, DONE end-of-game pulse.
module factor_game_ctrl #(
    parameter int READY_CYC  = 50_000_000,
    parameter int SHOW_CYC   = 100_000_000,
    parameter int INPUT_CYC  = 250_000_000,
    parameter int RESULT_CYC = 100_000_000,
    parameter int ROUNDS     = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ENTER,
    input  logic [3:0] SW,
    output logic [3:0] STATE,
    output logic [3:0] QUE,
    output logic [3:0] DIN,
    output logic [3:0] SCORE,
    output logic [3:0] ROUND,
    output logic       DONE
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'b0000,
        S_READY    = 4'b0010,
        S_QUESTION = 4'b0011,
        S_INPUT    = 4'b0100,
        S_CORRECT  = 4'b0111,
        S_MISS     = 4'b1000
    } state_t;

    localparam logic [31:0] T_READY  = 32'(READY_CYC - 1);
    localparam logic [31:0] T_SHOW   = 32'(SHOW_CYC - 1);
    localparam logic [31:0] T_INPUT  = 32'(INPUT_CYC - 1);
    localparam logic [31:0] T_RESULT = 32'(RESULT_CYC - 1);
    localparam logic [3:0]  ROUNDS_L = 4'(ROUNDS);

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        start_q, enter_q;
    logic [3:0]  que_q, que_d;
    logic [3:0]  din_q, din_d;
    logic [3:0]  score_q, score_d;
    logic [3:0]  round_q, round_d;
    logic        done_q, done_d;

    logic        start_e, enter_e;
    logic [3:0]  que_digit;
    logic [3:0]  round_inc;

    assign start_e   = START & ~start_q;
    assign enter_e   = ENTER & ~enter_q;
    assign round_inc = round_q + 4'd1;

    // Fold the low nibble 10..15 onto 4..9 so the question is always a decimal digit.
    assign que_digit = (lfsr_q[3:0] >= 4'd10) ? (lfsr_q[3:0] - 4'd6) : lfsr_q[3:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            lfsr_q  <= 8'h01;
            start_q <= 1'b0;
            enter_q <= 1'b0;
            que_q   <= '0;
            din_q   <= '0;
            score_q <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lfsr_q  <= lfsr_d;
            start_q <= START;
            enter_q <= ENTER;
            que_q   <= que_d;
            din_q   <= din_d;
            score_q <= score_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        que_d   = que_q;
        din_d   = din_q;
        score_d = score_q;
        round_d = round_q;
        done_d  = 1'b0;
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        case (state_q)
            S_IDLE: begin
                if (start_e) begin
                    score_d = '0;
                    round_d = '0;
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (timer_q == T_READY) begin
                    que_d   = que_digit;
                    state_d = S_QUESTION;
                end
            end
            S_QUESTION: begin
                if (timer_q == T_SHOW) begin
                    state_d = S_INPUT;
                end
            end
            S_INPUT: begin
                din_d = SW;
                // A press on the last allowed cycle is still judged, not timed out.
                if (enter_e) begin
                    if (SW == que_q) begin
                        score_d = score_q + 4'd1;
                        state_d = S_CORRECT;
                    end else begin
                        state_d = S_MISS;
                    end
                end else if (timer_q == T_INPUT) begin
                    state_d = S_MISS;
                end
            end
            S_CORRECT, S_MISS: begin
                if (timer_q == T_RESULT) begin
                    round_d = round_inc;
                    if (round_inc == ROUNDS_L) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_READY;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // One shared phase timer: zero on entry to every phase, idle in IDLE.
        if ((state_d != state_q) || (state_q == S_IDLE)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 32'd1;
        end
    end

    assign STATE = state_q;
    assign QUE   = que_q;
    assign DIN   = din_q;
    assign SCORE = score_q;
    assign ROUND = round_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_factor_game_ctrl.sv
// Testbench for factor_game_ctrl: scenario tasks with a sequence-level reference model.
// Expected question digits come from an LFSR sequence generator indexed by clock edges since reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_factor_game_ctrl;

    localparam int RC = 4;
    localparam int SC = 6;
    localparam int IC = 20;
    localparam int XC = 3;
    localparam int NR = 2;

    localparam logic [3:0] ST_IDLE  = 4'b0000;
    localparam logic [3:0] ST_READY = 4'b0010;
    localparam logic [3:0] ST_Q     = 4'b0011;
    localparam logic [3:0] ST_IN    = 4'b0100;
    localparam logic [3:0] ST_OK    = 4'b0111;
    localparam logic [3:0] ST_MISS  = 4'b1000;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       enter = 1'b0;
    logic [3:0] sw    = 4'd0;
    logic [3:0] state_o, que_o, din_o, score_o, round_o;
    logic       done_o;

    int n_tests = 0;
    int n_fail  = 0;
    int edges   = 0;
    int exp_score = 0;
    int exp_round = 0;

    factor_game_ctrl #(
        .READY_CYC (RC),
        .SHOW_CYC  (SC),
        .INPUT_CYC (IC),
        .RESULT_CYC(XC),
        .ROUNDS    (NR)
    ) dut (
        .CLK  (clk),
        .RST  (rst),
        .START(start),
        .ENTER(enter),
        .SW   (sw),
        .STATE(state_o),
        .QUE  (que_o),
        .DIN  (din_o),
        .SCORE(score_o),
        .ROUND(round_o),
        .DONE (done_o)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset was released.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // LFSR value after n steps from the reset seed.
    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] l;
        l = 8'h01;
        for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        return l;
    endfunction

    // Digit latched on rising edge number e uses the LFSR value present before that edge.
    function automatic logic [3:0] exp_que(input int e);
        logic [7:0] l;
        l = lfsr_at(e - 1);
        return (l[3:0] >= 4'd10) ? (l[3:0] - 4'd6) : l[3:0];
    endfunction

    task automatic measure(output logic [3:0] st, output int n);
        st = state_o;
        n  = 0;
        while (state_o == st && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // From the first READY cycle to the first INPUT cycle, checking durations and the digit.
    task automatic ready_question(input string tag);
        logic [3:0] st;
        logic [3:0] eq;
        int n;
        measure(st, n);
        n_tests++;
        if (st !== ST_READY || n != RC) begin
            n_fail++;
            $display("FAIL %s_ready: state %b for %0d cycles, expected %b for %0d", tag, st, n, ST_READY, RC);
        end
        eq = exp_que(edges);
        n_tests++;
        if (que_o !== eq || que_o > 4'd9) begin
            n_fail++;
            $display("FAIL %s_que: got %0d expected %0d", tag, que_o, eq);
        end
        measure(st, n);
        n_tests++;
        if (st !== ST_Q || n != SC || state_o !== ST_IN) begin
            n_fail++;
            $display("FAIL %s_question: state %b for %0d cycles then %b, expected %b for %0d then %b",
                     tag, st, n, state_o, ST_Q, SC, ST_IN);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({state_o, que_o, din_o, score_o, round_o, done_o} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {state_o, que_o, din_o, score_o, round_o, done_o});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (state_o !== ST_IDLE) begin
                n_fail++;
                $display("FAIL reset_idle: got %b expected %b", state_o, ST_IDLE);
            end
        end
    endtask

    task automatic test_correct_round();
        logic [3:0] st;
        int n;
        pulse_start();
        n_tests++;
        if (state_o !== ST_READY || score_o !== 4'd0 || round_o !== 4'd0) begin
            n_fail++;
            $display("FAIL start_ready: state %b score %0d round %0d, expected %b 0 0", state_o, score_o, round_o, ST_READY);
        end
        ready_question("correct");
        sw = que_o;
        @(negedge clk);
        @(negedge clk);
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        exp_score = 1;
        n_tests++;
        if (state_o !== ST_OK || score_o !== 4'(exp_score) || din_o !== que_o) begin
            n_fail++;
            $display("FAIL correct_judge: state %b score %0d din %0d, expected %b %0d %0d",
                     state_o, score_o, din_o, ST_OK, exp_score, que_o);
        end
        measure(st, n);
        exp_round = 1;
        n_tests++;
        if (st !== ST_OK || n != XC || state_o !== ST_READY || round_o !== 4'(exp_round) || score_o !== 4'(exp_score)) begin
            n_fail++;
            $display("FAIL correct_result: %b x%0d then %b round %0d score %0d, expected %b x%0d then %b round %0d score %0d",
                     st, n, state_o, round_o, score_o, ST_OK, XC, ST_READY, exp_round, exp_score);
        end
    endtask

    task automatic test_wrong_held();
        logic [3:0] prev;
        int misses;
        int dones;
        ready_question("wrong");
        sw = (que_o == 4'd9) ? 4'd0 : que_o + 4'd1;
        enter = 1'b1;
        prev = state_o;
        misses = 0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (state_o == ST_MISS && prev != ST_MISS) misses++;
            if (i == 0) begin
                n_tests++;
                if (state_o !== ST_MISS || score_o !== 4'(exp_score) || din_o !== sw) begin
                    n_fail++;
                    $display("FAIL wrong_judge: state %b score %0d din %0d, expected %b %0d %0d",
                             state_o, score_o, din_o, ST_MISS, exp_score, sw);
                end
            end
            if (done_o === 1'b1) begin
                dones++;
                n_tests++;
                if (state_o !== ST_IDLE || round_o !== 4'(NR) || score_o !== 4'(exp_score)) begin
                    n_fail++;
                    $display("FAIL done_state: state %b round %0d score %0d, expected %b %0d %0d",
                             state_o, round_o, score_o, ST_IDLE, NR, exp_score);
                end
            end
            prev = state_o;
        end
        enter = 1'b0;
        exp_round = NR;
        n_tests++;
        if (misses != 1) begin
            n_fail++;
            $display("FAIL held_enter_misses: got %0d expected 1", misses);
        end
        n_tests++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL done_pulses: got %0d expected 1", dones);
        end
        n_tests++;
        if (state_o !== ST_IDLE || score_o !== 4'(exp_score) || round_o !== 4'(exp_round)) begin
            n_fail++;
            $display("FAIL game_end_hold: state %b score %0d round %0d, expected %b %0d %0d",
                     state_o, score_o, round_o, ST_IDLE, exp_score, exp_round);
        end
        pulse_start();
        exp_score = 0;
        exp_round = 0;
        n_tests++;
        if (state_o !== ST_READY || score_o !== 4'd0 || round_o !== 4'd0) begin
            n_fail++;
            $display("FAIL restart_clear: state %b score %0d round %0d, expected %b 0 0", state_o, score_o, round_o, ST_READY);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] st;
        int n;
        ready_question("timeout");
        measure(st, n);
        n_tests++;
        if (st !== ST_IN || n != IC || state_o !== ST_MISS || din_o !== sw) begin
            n_fail++;
            $display("FAIL timeout_input: %b x%0d then %b din %0d, expected %b x%0d then %b din %0d",
                     st, n, state_o, din_o, ST_IN, IC, ST_MISS, sw);
        end
        measure(st, n);
        exp_round = 1;
        n_tests++;
        if (n != XC || state_o !== ST_READY || round_o !== 4'(exp_round) || score_o !== 4'(exp_score)) begin
            n_fail++;
            $display("FAIL timeout_result: x%0d then %b round %0d score %0d, expected x%0d then %b round %0d score %0d",
                     n, state_o, round_o, score_o, XC, ST_READY, exp_round, exp_score);
        end
    endtask

    task automatic test_question_range();
        logic [3:0] st;
        logic [3:0] q;
        logic [3:0] exp_st;
        int n;
        int mode;
        int at;
        for (int r = 0; r < 200; r++) begin
            ready_question("range");
            q = que_o;
            mode = $urandom_range(0, 2);
            if (mode < 2) begin
                at = (r % 7 == 0) ? IC - 1 : $urandom_range(0, IC - 1);
                sw = (mode == 0) ? q : 4'((int'(q) + 1 + $urandom_range(0, 8)) % 10);
                repeat (at) @(negedge clk);
                enter = 1'b1;
                @(negedge clk);
                enter = 1'b0;
                exp_st = (mode == 0) ? ST_OK : ST_MISS;
                if (mode == 0) exp_score++;
                n_tests++;
                if (state_o !== exp_st || din_o !== sw || score_o !== 4'(exp_score)) begin
                    n_fail++;
                    $display("FAIL range_judge r%0d at%0d: state %b din %0d score %0d, expected %b %0d %0d",
                             r, at, state_o, din_o, score_o, exp_st, sw, exp_score);
                end
            end else begin
                measure(st, n);
                n_tests++;
                if (n != IC || state_o !== ST_MISS) begin
                    n_fail++;
                    $display("FAIL range_timeout r%0d: %0d cycles then %b, expected %0d then %b", r, n, state_o, IC, ST_MISS);
                end
            end
            measure(st, n);
            exp_round++;
            if (exp_round == NR) begin
                n_tests++;
                if (n != XC || state_o !== ST_IDLE || done_o !== 1'b1 || round_o !== 4'(NR) || score_o !== 4'(exp_score)) begin
                    n_fail++;
                    $display("FAIL range_end r%0d: x%0d state %b done %b round %0d score %0d, expected x%0d %b 1 %0d %0d",
                             r, n, state_o, done_o, round_o, score_o, XC, ST_IDLE, NR, exp_score);
                end
                pulse_start();
                exp_score = 0;
                exp_round = 0;
            end else begin
                n_tests++;
                if (n != XC || state_o !== ST_READY || round_o !== 4'(exp_round) || score_o !== 4'(exp_score)) begin
                    n_fail++;
                    $display("FAIL range_next r%0d: x%0d state %b round %0d score %0d, expected x%0d %b %0d %0d",
                             r, n, state_o, round_o, score_o, XC, ST_READY, exp_round, exp_score);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        ready_question("mid");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({state_o, que_o, din_o, score_o, round_o, done_o} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h expected 0", {state_o, que_o, din_o, score_o, round_o, done_o});
        end
        @(negedge clk);
        rst = 1'b0;
        exp_score = 0;
        exp_round = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (state_o !== ST_IDLE) begin
                n_fail++;
                $display("FAIL reset_mid_idle: got %b expected %b", state_o, ST_IDLE);
            end
        end
        pulse_start();
        ready_question("post_reset");
    endtask

    initial begin
        test_reset();
        test_correct_round();
        test_wrong_held();
        test_timeout();
        test_question_range();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/factor_game_ctrl.md
# factor_game_ctrl

Round sequencer for the factorization quiz: it drives the `STATE`, `QUE` and `DIN` codes that the 7-segment decoder turns into the READY, question, entry and result displays. It takes the START and ENTER push-buttons and the 4-bit answer switches, and generates a pseudo-random question digit. It times each phase, judges the answer, keeps score and ends the game after a fixed number of rounds.

## Interface
- READY_CYC, 50_000_000, cycles spent in READY per round (≥2)
- SHOW_CYC, 100_000_000, cycles the question digit is shown (≥2)
- INPUT_CYC, 250_000_000, cycles allowed for answer entry before timeout (≥2)
- RESULT_CYC, 100_000_000, cycles the result is shown (≥2)
- ROUNDS, 5, rounds per game (1..15)
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  start button level, active-high, already synchronized to CLK
- ENTER  in  1  enter button level, active-high, already synchronized to CLK
- SW  in  4  answer switches
- STATE  out  4  phase code: IDLE 4'b0000, READY 4'b0010, QUESTION 4'b0011, INPUT 4'b0100, CORRECT 4'b0111, MISS 4'b1000
- QUE  out  4  question digit, always 0..9
- DIN  out  4  registered answer value
- SCORE  out  4  correct answers this game
- ROUND  out  4  rounds completed this game
- DONE  out  1  one-cycle pulse when the game ends

## Operation
- Reset (async, immediate, also mid-round): STATE=IDLE, QUE=0, DIN=0, SCORE=0, ROUND=0, DONE=0, timer=0, LFSR=8'h01, button history regs=0.
- Edge detect: start_e = START & ~START_q and enter_e = ENTER & ~ENTER_q, where the _q registers hold the previous-cycle levels. A held button therefore produces exactly one event.
- LFSR: 8-bit, free-running every cycle in all states. next = {l[6:0], l[7]^l[5]^l[4]^l[3]}. Sequence after reset: 01, 02, 04, 08, 11, 23, ...
- A single timer counts up in READY, QUESTION, INPUT, CORRECT and MISS. It clears on every state change and is 0 on entry.
- IDLE: on start_e, clear SCORE and ROUND, then go to READY. ENTER is ignored.
- READY: when timer==READY_CYC-1, go to QUESTION. On that same edge, latch QUE = (l[3:0]≥10) ? l[3:0]-6 : l[3:0], using the LFSR value at that edge.
- QUESTION: when timer==SHOW_CYC-1, go to INPUT.
- INPUT: DIN <= SW every cycle.
  - enter_e: DIN <= SW, then go to CORRECT if SW==QUE, else to MISS.
  - timer==INPUT_CYC-1 without enter_e: go to MISS, and DIN keeps its last sample.
  - If enter_e and the timeout fall on the same cycle, enter_e wins.
- CORRECT: on entry, SCORE increments. On exit, ROUND increments.
- CORRECT and MISS: when timer==RESULT_CYC-1, increment ROUND.
  - If the new ROUND==ROUNDS, go to IDLE and pulse DONE for that one cycle.
  - Otherwise go to READY.
- START and ENTER events outside the states listed above are ignored.
- QUE and DIN hold their values in every state in which they are not written. SCORE and ROUND hold after the game until the next start_e.
- SCORE and ROUND never exceed ROUNDS, so no wrap-around handling is needed.
- Unused STATE encodings are unreachable. If one is ever decoded, the next state is IDLE.

## Timing
- Every output is a register; there is no combinational path from an input to an output.
- START rises before edge k: STATE=READY from edge k.
- READY lasts exactly READY_CYC cycles, QUESTION exactly SHOW_CYC, and CORRECT/MISS exactly RESULT_CYC.
- INPUT lasts at most INPUT_CYC cycles.
- ENTER rises before edge k in INPUT: STATE, DIN and SCORE are all updated at edge k.
- DONE is high for the single cycle following the final result phase, concurrent with STATE=IDLE.

## Test plan
- Parameters READY_CYC=4, SHOW_CYC=6, INPUT_CYC=20, RESULT_CYC=3, ROUNDS=2 for all scenarios.
- Reset and LFSR:
  - Assert RST mid-INPUT: all outputs return to their reset values immediately, with no clock edge needed.
  - After release, with START low, STATE stays 0000.
- Correct round:
  - Stimulus: START pulse, then SW=QUE and an ENTER pulse during INPUT.
  - Required sequence: STATE 0010 (4 cycles), 0011 (6 cycles), 0100, 0111 (3 cycles).
  - Then SCORE=1, ROUND=1, DIN=QUE.
- Wrong answer and held button:
  - Stimulus: SW=(QUE+1)%10, ENTER held high for 10 cycles.
  - Required: exactly one transition to 1000, SCORE unchanged, DIN=SW.
- Timeout: no ENTER in INPUT, so STATE goes 0100 to 1000 after exactly 20 cycles.
- Game end:
  - After the 2nd result phase: STATE=0000 with DONE high for 1 cycle, and SCORE/ROUND hold.
  - A new START clears both to 0.
- Question range: run 200 rounds with a reference LFSR model. QUE matches the model and is always ≤9. Simultaneous enter_e and timeout goes to CORRECT/MISS per the compare, never a forced MISS.
